// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and the most-significant-digit helper
// Used by bcd_digit_cell, bcd_counter_param and the averaging divider.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  // Index of the highest nonzero digit among the low n digits of bcd; 0 for an all-zero value.
  function automatic int msd_of(input logic [63:0] bcd, input int n);
    msd_of = 0;
    for (int k = 0; k < 16; k++)
      if (k < n && bcd[4*k +: 4] != BCD_MIN) msd_of = k;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one registered BCD digit with combinational carry/borrow out
// Ports: clk, rst_n (async active-low), step_in (carry/borrow in), down, clr, load,
//        ld_val (raw load digit, clamped to 9 here), digit (registered),
//        step_out (carry when up, borrow when down), nxt (next-state digit).
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_in,
  input  logic       down,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t ld_val,
  output bcd_digit_t digit,
  output logic       step_out,
  output bcd_digit_t nxt
);
  bcd_digit_t stepped;
  always_comb begin
    step_out = step_in & (down ? digit == BCD_MIN : digit == BCD_MAX);
    stepped  = down ? (digit == BCD_MIN ? BCD_MAX : digit - 4'd1)
                    : (digit == BCD_MAX ? BCD_MIN : digit + 4'd1);
    nxt      = clr ? BCD_MIN
             : load ? (ld_val > BCD_MAX ? BCD_MAX : ld_val)
             : step_in ? stepped : digit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit <= BCD_MIN;
    else digit <= nxt;
endmodule

// File: rtl/bcd_counter_param.sv
// bcd_counter_param: cascaded NUM_DIGITS BCD event counter with wrap/saturate and MSD tracking
// Ports: clk, rst_n (async active-low), clr, load, load_bcd, inc, down in;
//        count_bcd, msd_idx, wrap, at_limit, ovf, load_err out (all registered).
module bcd_counter_param
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 11,
  parameter bit SATURATE   = 1'b0,
  parameter int MSD_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic                    inc,
  input  logic                    down,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [MSD_W-1:0]        msd_idx,
  output logic                    wrap,
  output logic                    at_limit,
  output logic                    ovf,
  output logic                    load_err
);
  localparam logic [4*NUM_DIGITS-1:0] ALL9 = {NUM_DIGITS{BCD_MAX}};
  logic [NUM_DIGITS:0]     step;
  logic [NUM_DIGITS-1:0]   bad;
  logic [4*NUM_DIGITS-1:0] nxt;
  logic                    lim_now, hit;
  // A step at the limit is blocked at digit 0 when saturating; otherwise the
  // carry/borrow out of the top digit marks the wrap.
  always_comb begin
    lim_now = down ? count_bcd == '0 : count_bcd == ALL9;
    step[0] = inc & ~(SATURATE && lim_now);
    hit     = ~clr & ~load & (SATURATE ? inc & lim_now : step[NUM_DIGITS]);
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_in  (step[i]),
      .down     (down),
      .clr      (clr),
      .load     (load),
      .ld_val   (load_bcd[4*i +: 4]),
      .digit    (count_bcd[4*i +: 4]),
      .step_out (step[i+1]),
      .nxt      (nxt[4*i +: 4])
    );
    assign bad[i] = load_bcd[4*i +: 4] > BCD_MAX;
  end
  // at_limit is registered against the next count and the direction sampled on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      msd_idx  <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      msd_idx  <= MSD_W'(msd_of(64'(nxt), NUM_DIGITS));
      wrap     <= hit & !SATURATE;
      at_limit <= SATURATE && (down ? nxt == '0 : nxt == ALL9);
      ovf      <= clr ? 1'b0 : ovf | hit;
      load_err <= ~clr & load & (|bad);
    end
endmodule

// File: tb/tb_bcd_counter_param.sv
// tb_bcd_counter_param: scoreboard bench over an 11-digit wrapping, a 3-digit wrapping and a 3-digit saturating counter
module tb_bcd_counter_param;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0, load = 1'b0, inc = 1'b0, down = 1'b0, probe = 1'b0;
  logic [43:0] ld = '0;
  logic [43:0] cnt_a;
  logic [11:0] cnt_b, cnt_c;
  logic [3:0]  msd_a, msd_b, msd_c;
  logic w_a, al_a, o_a, le_a, w_b, al_b, o_b, le_b, w_c, al_c, o_c, le_c;
  typedef struct packed {logic [1:0] id; logic [51:0] v;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bcd_counter_param #(.NUM_DIGITS(11), .SATURATE(1'b0), .MSD_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(ld), .inc(inc), .down(down),
    .count_bcd(cnt_a), .msd_idx(msd_a), .wrap(w_a), .at_limit(al_a), .ovf(o_a), .load_err(le_a));
  bcd_counter_param #(.NUM_DIGITS(3), .SATURATE(1'b0), .MSD_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(ld[11:0]), .inc(inc), .down(down),
    .count_bcd(cnt_b), .msd_idx(msd_b), .wrap(w_b), .at_limit(al_b), .ovf(o_b), .load_err(le_b));
  bcd_counter_param #(.NUM_DIGITS(3), .SATURATE(1'b1), .MSD_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(ld[11:0]), .inc(inc), .down(down),
    .count_bcd(cnt_c), .msd_idx(msd_c), .wrap(w_c), .at_limit(al_c), .ovf(o_c), .load_err(le_c));

  // Observed word: {count, msd_idx, wrap, at_limit, ovf, load_err}
  function automatic logic [51:0] obs(input logic [1:0] id);
    case (id)
      2'd0:    obs = {cnt_a, msd_a, w_a, al_a, o_a, le_a};
      2'd1:    obs = {32'd0, cnt_b, msd_b, w_b, al_b, o_b, le_b};
      default: obs = {32'd0, cnt_c, msd_c, w_c, al_c, o_c, le_c};
    endcase
  endfunction

  task automatic ex(input int id, input logic [43:0] c, input logic [3:0] m, input logic [3:0] f);
    q.push_back({2'(id), c, m, f});
  endtask

  task automatic ex3(input logic [43:0] c, input logic [3:0] m, input logic [3:0] f);
    for (int i = 0; i < 3; i++) ex(i, c, m, f);
  endtask

  task automatic cyc(input logic c, input logic l, input logic i, input logic d, input logic [43:0] v);
    @(negedge clk);
    clr = c; load = l; inc = i; down = d; ld = v;
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or posedge probe);
      while (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (obs(e.id) !== e.v) begin
          fails++;
          $display("FAIL dut%0d t=%0t got cnt=%h msd=%0d w/al/ovf/le=%b want cnt=%h msd=%0d w/al/ovf/le=%b",
                   e.id, $time, obs(e.id)[51:8], obs(e.id)[7:4], obs(e.id)[3:0],
                   e.v[51:8], e.v[7:4], e.v[3:0]);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    ex3(44'h0, 4'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 44'h457);
    ex3(44'h457, 4'd2, 4'b0000);
    cyc(0, 0, 1, 0, 44'h0);
    ex(0, 44'h458, 4'd2, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    ex3(44'h0, 4'd0, 4'b0000);
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    ex3(44'h1, 4'd0, 4'b0000);
    cyc(0, 1, 1, 0, 44'h999);
    ex(0, 44'h999, 4'd2, 4'b0000);
    ex(1, 44'h999, 4'd2, 4'b0000);
    ex(2, 44'h999, 4'd2, 4'b0100);
    cyc(0, 0, 1, 0, 44'h0);
    ex(0, 44'h1000, 4'd3, 4'b0000);
    ex(1, 44'h0, 4'd0, 4'b1010);
    ex(2, 44'h999, 4'd2, 4'b0110);
    cyc(0, 0, 0, 0, 44'h0);
    ex(0, 44'h1000, 4'd3, 4'b0000);
    ex(1, 44'h0, 4'd0, 4'b0010);
    ex(2, 44'h999, 4'd2, 4'b0110);
    cyc(1, 1, 1, 0, 44'h42);
    ex3(44'h0, 4'd0, 4'b0000);
    cyc(0, 1, 1, 0, 44'h42);
    ex3(44'h42, 4'd1, 4'b0000);
    cyc(1, 0, 0, 0, 44'h0);
    ex3(44'h0, 4'd0, 4'b0000);
    cyc(0, 0, 1, 1, 44'h0);
    ex(0, 44'h99999999999, 4'd10, 4'b1010);
    ex(1, 44'h999, 4'd2, 4'b1010);
    ex(2, 44'h0, 4'd0, 4'b0110);
    cyc(0, 0, 1, 1, 44'h0);
    ex(0, 44'h99999999998, 4'd10, 4'b0010);
    ex(1, 44'h998, 4'd2, 4'b0010);
    ex(2, 44'h0, 4'd0, 4'b0110);
    cyc(0, 0, 1, 1, 44'h0);
    ex(0, 44'h99999999997, 4'd10, 4'b0010);
    ex(1, 44'h997, 4'd2, 4'b0010);
    ex(2, 44'h0, 4'd0, 4'b0110);
    cyc(0, 1, 0, 0, 44'h3C);
    ex3(44'h39, 4'd1, 4'b0011);
    cyc(0, 0, 0, 0, 44'h0);
    ex3(44'h39, 4'd1, 4'b0010);
    cyc(1, 0, 0, 0, 44'h0);
    ex3(44'h0, 4'd0, 4'b0000);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
